pipeline_fetch_ctrl: RTL and testbench

- Fetch sequencer for the 5-stage pipeline's IF stage.
- Owns the program counter and issues one instruction-memory request at a time over a req/gnt/rvalid handshake, so the memory may have variable latency.
- Presents fetched instructions to the IF/ID boundary with valid/stall flow control, and applies branch redirects from EX, discarding wrong-path responses that are already in flight.

---
 rtl/pipeline_fetch_ctrl_pkg.sv | 40 ++++
 rtl/fetch_skid_buf.sv | 51 +++++
 rtl/pipeline_fetch_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_pipeline_fetch_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_fetch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_fetch_ctrl_pkg
// Shared definitions for the IF-stage fetch sequencer:
//   XLEN          - architectural register / address width
//   NOP_INSTR     - canonical bubble instruction (addi x0,x0,0)
//   fetch_state_e - fetch FSM encoding (IDLE/REQ/WAIT/HOLD)
//   fetch_slot_t  - one IF/ID payload {instr, pc, pc_plus4}
//   pc_incr       - sequential next-PC, wraps modulo 2^XLEN
//   align_pc      - forces a redirect target to word alignment
// -----------------------------------------------------------------------------
package pipeline_fetch_ctrl_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } fetch_slot_t;

  // Wraps silently: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
  function automatic logic [XLEN-1:0] pc_incr(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

  // Low two bits of a redirect target carry no meaning for 32-bit fetch.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] target);
    return target & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// -----------------------------------------------------------------------------
// fetch_skid_buf
// One-entry holding buffer for a fetched {instr, pc, pc_plus4} triple that
// returned from memory while the IF/ID slot was full and stalled.
// Ports:
//   clk_i     in   clock
//   reset_i   in   synchronous active-high reset (empties the entry)
//   load_i    in   capture data_i
//   unload_i  in   entry has been moved out; mark empty
//   flush_i   in   discard the entry (redirect); wins over load_i
//   data_i    in   triple to capture
//   valid_o   out  entry holds a triple
//   data_o    out  held triple
// -----------------------------------------------------------------------------
module fetch_skid_buf
  import pipeline_fetch_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        load_i,
  input  logic        unload_i,
  input  logic        flush_i,
  input  fetch_slot_t data_i,
  output logic        valid_o,
  output fetch_slot_t data_o
);

  logic        valid_q;
  fetch_slot_t data_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
    end else if (flush_i || unload_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
    end
  end

  // Payload carries no reset; valid_q alone qualifies it.
  always_ff @(posedge clk_i) begin
    if (load_i && !flush_i) begin
      data_q <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipeline_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_fetch_ctrl
// IF-stage fetch sequencer. Owns the PC, keeps exactly one instruction-memory
// request outstanding over a req/gnt/rvalid handshake, and presents fetched
// instructions to the IF/ID boundary with valid/stall flow control. Branch
// redirects from EX retarget the PC and discard any wrong-path response that
// is already in flight.
// Ports:
//   clk_i          in   clock
//   reset_i        in   synchronous active-high reset, dominates all inputs
//   pc_select_i    in   redirect request from EX
//   pc_new_i       in   redirect target (bits [1:0] ignored)
//   stall_i        in   ID cannot accept; IF/ID output is held
//   imem_req_o     out  fetch request valid
//   imem_addr_o    out  fetch byte address (always the current PC)
//   imem_gnt_i     in   request accepted this cycle
//   imem_rvalid_i  in   read data valid, one per granted request
//   imem_rdata_i   in   instruction word
//   if_valid_o     out  IF/ID slot holds a valid instruction
//   if_instr_o     out  instruction (NOP_INSTR when slot is empty)
//   if_pc_o        out  address of if_instr_o
//   if_pc_plus4_o  out  if_pc_o + 4
// -----------------------------------------------------------------------------
module pipeline_fetch_ctrl
  import pipeline_fetch_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = pipeline_fetch_ctrl_pkg::NOP_INSTR
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            pc_select_i,
  input  logic [XLEN-1:0] pc_new_i,
  input  logic            stall_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            if_valid_o,
  output logic [XLEN-1:0] if_instr_o,
  output logic [XLEN-1:0] if_pc_o,
  output logic [XLEN-1:0] if_pc_plus4_o
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            drop_q, drop_d;

  logic            slot_valid_q, slot_valid_d;
  fetch_slot_t     slot_q, slot_d;

  logic            skid_load, skid_unload, skid_flush;
  logic            skid_valid;
  fetch_slot_t     skid_data;

  fetch_slot_t     rsp_slot;
  logic            consume;

  // Response triple built from the address of the granted request, not the
  // live PC, which has already moved on by the time data returns.
  assign rsp_slot = '{instr: imem_rdata_i, pc: req_pc_q, pc_plus4: pc_incr(req_pc_q)};

  assign consume = slot_valid_q && !stall_i;

  fetch_skid_buf u_skid (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .flush_i  (skid_flush),
    .data_i   (rsp_slot),
    .valid_o  (skid_valid),
    .data_o   (skid_data)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    drop_d       = drop_q;
    slot_valid_d = slot_valid_q;
    slot_d       = slot_q;
    skid_load    = 1'b0;
    skid_unload  = 1'b0;
    skid_flush   = 1'b0;

    // A consumed slot empties unless something below refills it this cycle.
    if (consume) begin
      slot_valid_d = 1'b0;
      slot_d.instr = NOP_INSTR;
    end

    case (state_q)
      IDLE: begin
        state_d = REQ;
      end
      REQ: begin
        if (imem_gnt_i) begin
          req_pc_d = pc_q;
          pc_d     = pc_incr(pc_q);
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid_i) begin
          state_d = REQ;
          if (drop_q) begin
            drop_d = 1'b0;
          end else if (!slot_valid_q || !stall_i) begin
            slot_valid_d = 1'b1;
            slot_d       = rsp_slot;
          end else begin
            skid_load = 1'b1;
            state_d   = HOLD;
          end
        end
      end
      HOLD: begin
        if (!stall_i) begin
          state_d = REQ;
          if (skid_valid) begin
            slot_valid_d = 1'b1;
            slot_d       = skid_data;
            skid_unload  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Redirect overrides the normal transitions: the PC takes the target
    // (never +4), the IF/ID slot and skid are emptied, and a response still
    // owed by memory is marked for discard.
    if (pc_select_i) begin
      pc_d         = align_pc(pc_new_i);
      slot_valid_d = 1'b0;
      slot_d       = slot_q;
      slot_d.instr = NOP_INSTR;
      skid_load    = 1'b0;
      skid_unload  = 1'b0;
      skid_flush   = 1'b1;
      case (state_q)
        REQ: begin
          if (imem_gnt_i) begin
            drop_d = 1'b1;
          end
        end
        WAIT: begin
          if (imem_rvalid_i) begin
            drop_d  = 1'b0;
            state_d = REQ;
          end else begin
            drop_d = 1'b1;
          end
        end
        HOLD: begin
          state_d = REQ;
        end
        default: begin
        end
      endcase
    end
  end

  // ---- IF stage register boundary: FSM, PC and IF/ID slot ----
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      drop_q       <= 1'b0;
      slot_valid_q <= 1'b0;
      slot_q       <= '{instr: NOP_INSTR, pc: '0, pc_plus4: XLEN'(4)};
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_q       <= drop_d;
      slot_valid_q <= slot_valid_d;
      slot_q       <= slot_d;
    end
  end

  // Only meaningful while WAIT/HOLD, which are always entered through a
  // grant that loads it, so it needs no reset.
  always_ff @(posedge clk_i) begin
    req_pc_q <= req_pc_d;
  end

  assign imem_req_o    = (state_q == REQ);
  assign imem_addr_o   = pc_q;
  assign if_valid_o    = slot_valid_q;
  assign if_instr_o    = slot_q.instr;
  assign if_pc_o       = slot_q.pc;
  assign if_pc_plus4_o = slot_q.pc_plus4;

endmodule

// File: tb/tb_pipeline_fetch_ctrl.sv
module tb_pipeline_fetch_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_i       = 1'b1;
  logic        pc_select_i   = 1'b0;
  logic [31:0] pc_new_i      = '0;
  logic        stall_i       = 1'b0;
  logic        imem_gnt_i    = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i  = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        if_valid_o;
  logic [31:0] if_instr_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_pc_plus4_o;

  pipeline_fetch_ctrl dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .pc_select_i   (pc_select_i),
    .pc_new_i      (pc_new_i),
    .stall_i       (stall_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .if_valid_o    (if_valid_o),
    .if_instr_o    (if_instr_o),
    .if_pc_o       (if_pc_o),
    .if_pc_plus4_o (if_pc_plus4_o)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcp4;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // memory model configuration and state
  int          gnt_budget = 0;
  int          gnt_delay  = 0;
  int          lat        = 1;
  int          gnt_wait   = 0;
  int          lat_cnt    = 0;
  int          resp_cnt   = 0;
  int          gnt_cnt    = 0;
  bit          pending    = 0;
  bit          allow_stale = 0;
  bit          prev_waiting = 0;
  logic [31:0] pend_addr  = '0;
  logic [31:0] prev_addr  = '0;
  logic [31:0] gnt_addrs[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0050_0093 ^ {a[23:0], 8'h00};
  endfunction

  function automatic exp_t mk(input logic [31:0] pc);
    exp_t e;
    e.instr = mem_word(pc);
    e.pc    = pc;
    e.pcp4  = pc + 32'd4;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(input int maxc, input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < maxc) begin
      step();
      n++;
    end
    check({name, "_drain_left"}, exp_q.size(), 0);
  endtask

  task automatic wait_resp(input int target, input int maxc);
    int n = 0;
    while (resp_cnt < target && n < maxc) begin
      step();
      n++;
    end
    check("resp_wait", resp_cnt, target);
  endtask

  task automatic wait_gnt(input int target, input int maxc);
    int n = 0;
    while (gnt_cnt < target && n < maxc) begin
      step();
      n++;
    end
    check("gnt_wait", gnt_cnt, target);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req"},   imem_req_o,    1'b0);
    check({tag, "_addr"},  imem_addr_o,   32'h0);
    check({tag, "_valid"}, if_valid_o,    1'b0);
    check({tag, "_instr"}, if_instr_o,    NOP);
    check({tag, "_pc"},    if_pc_o,       32'h0);
    check({tag, "_pcp4"},  if_pc_plus4_o, 32'h4);
  endtask

  task automatic do_reset();
    reset_i     = 1'b1;
    pc_select_i = 1'b0;
    stall_i     = 1'b0;
    step();
    step();
    reset_i = 1'b0;
    gnt_addrs.delete();
  endtask

  // Memory model: grants after gnt_delay cycles of request, returns data lat
  // cycles after the grant, watches the one-outstanding and address-stable rules.
  always begin
    @(posedge clk);
    #1;
    if (prev_waiting && !pc_select_i && !reset_i && imem_req_o) begin
      checks++;
      if (imem_addr_o !== prev_addr) begin
        errors++;
        $display("FAIL addr_stable: got %h expected %h", imem_addr_o, prev_addr);
      end
    end
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    if (pending) begin
      if (imem_req_o && !allow_stale) begin
        errors++;
        $display("FAIL one_outstanding: req while response owed for %h", pend_addr);
      end
      lat_cnt--;
      if (lat_cnt == 0) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = mem_word(pend_addr);
        pending       = 1'b0;
        resp_cnt++;
      end
    end else if (imem_req_o && gnt_budget > 0) begin
      if (gnt_wait >= gnt_delay) begin
        imem_gnt_i = 1'b1;
        pending    = 1'b1;
        lat_cnt    = lat;
        pend_addr  = imem_addr_o;
        gnt_addrs.push_back(imem_addr_o);
        gnt_budget--;
        gnt_cnt++;
        gnt_wait   = 0;
      end else begin
        gnt_wait++;
      end
    end
    prev_waiting = imem_req_o && !imem_gnt_i;
    prev_addr    = imem_addr_o;
  end

  // Scoreboard monitor: every consumed IF/ID slot must match the queue head.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset_i && if_valid_o && !stall_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: pc %h instr %h, nothing expected", if_pc_o, if_instr_o);
      end else begin
        e = exp_q.pop_front();
        if ({if_instr_o, if_pc_o, if_pc_plus4_o} !== e) begin
          errors++;
          $display("FAIL slot_out: got instr %h pc %h pc4 %h expected instr %h pc %h pc4 %h",
                   if_instr_o, if_pc_o, if_pc_plus4_o, e.instr, e.pc, e.pcp4);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    int g0;

    // reset state
    step();
    step();
    check_reset_vals("rst");
    reset_i = 1'b0;

    // sequential fetch, 1-cycle latency
    lat = 1; gnt_delay = 0;
    exp_q.push_back(mk(32'h0));
    exp_q.push_back(mk(32'h4));
    exp_q.push_back(mk(32'h8));
    gnt_budget = 3;
    wait_drain(100, "seq");
    check("seq_ngnt", gnt_addrs.size(), 3);
    for (int i = 0; i < 3 && i < gnt_addrs.size(); i++)
      check("seq_addr", gnt_addrs[i], i * 4);
    check("seq_next_addr", imem_addr_o, 32'hC);

    // stall with response returning -> HOLD, skid released after stall
    do_reset();
    stall_i = 1'b1;
    r0 = resp_cnt;
    exp_q.push_back(mk(32'h0));
    exp_q.push_back(mk(32'h4));
    gnt_budget = 2;
    wait_resp(r0 + 2, 100);
    step();
    for (int i = 0; i < 5; i++) begin
      check("hold_req", imem_req_o, 1'b0);
      check("hold_valid", if_valid_o, 1'b1);
      check("hold_instr", if_instr_o, mem_word(32'h0));
      step();
    end
    stall_i = 1'b0;
    step();
    check("skid_pc", if_pc_o, 32'h4);
    check("skid_instr", if_instr_o, mem_word(32'h4));
    wait_drain(50, "skid");

    // redirect while WAIT -> late response dropped
    do_reset();
    lat = 4;
    r0 = resp_cnt;
    g0 = gnt_cnt;
    gnt_budget = 1;
    wait_gnt(g0 + 1, 50);
    step();
    pc_select_i = 1'b1;
    pc_new_i    = 32'h103;
    step();
    pc_select_i = 1'b0;
    check("rdw_addr", imem_addr_o, 32'h100);
    wait_resp(r0 + 1, 50);
    step();
    check("rdw_valid", if_valid_o, 1'b0);
    check("rdw_req", imem_req_o, 1'b1);
    check("rdw_addr2", imem_addr_o, 32'h100);
    exp_q.push_back(mk(32'h100));
    gnt_budget = 1;
    wait_drain(100, "rdw");
    check("rdw_ngnt", gnt_addrs.size(), 2);
    if (gnt_addrs.size() == 2) check("rdw_gnt_addr", gnt_addrs[1], 32'h100);

    // redirect in the same cycle as the grant for pc 0x8
    do_reset();
    lat = 1;
    exp_q.push_back(mk(32'h0));
    exp_q.push_back(mk(32'h4));
    gnt_budget = 2;
    wait_drain(100, "rg_pre");
    check("rg_addr8", imem_addr_o, 32'h8);
    gnt_budget = 1;
    step();
    pc_select_i = 1'b1;
    pc_new_i    = 32'h40;
    step();
    pc_select_i = 1'b0;
    check("rg_ngnt", gnt_addrs.size(), 3);
    if (gnt_addrs.size() == 3) check("rg_gnt8", gnt_addrs[2], 32'h8);
    check("rg_addr40", imem_addr_o, 32'h40);
    exp_q.push_back(mk(32'h40));
    gnt_budget = 1;
    wait_drain(100, "rg");
    check("rg_ngnt2", gnt_addrs.size(), 4);
    if (gnt_addrs.size() == 4) check("rg_gnt40", gnt_addrs[3], 32'h40);

    // 4-cycle latency, grant withheld 3 cycles, intermittent stall, 20 fetches
    do_reset();
    lat = 4; gnt_delay = 3;
    for (int i = 0; i < 20; i++) exp_q.push_back(mk(i * 4));
    gnt_budget = 20;
    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
        stall_i = (n % 3 == 1);
        step();
        n++;
      end
    end
    stall_i = 1'b0;
    check("slow_drain_left", exp_q.size(), 0);
    check("slow_ngnt", gnt_addrs.size(), 20);
    gnt_delay = 0;

    // reset while WAIT, stale rvalid afterwards is ignored
    do_reset();
    allow_stale = 1'b1;
    lat = 6;
    r0 = resp_cnt;
    g0 = gnt_cnt;
    gnt_budget = 1;
    wait_gnt(g0 + 1, 50);
    step();
    reset_i = 1'b1;
    step();
    check_reset_vals("rstw");
    reset_i = 1'b0;
    wait_resp(r0 + 1, 50);
    step();
    step();
    check("stale_valid", if_valid_o, 1'b0);
    check("stale_instr", if_instr_o, NOP);
    check("stale_req", imem_req_o, 1'b1);
    check("stale_addr", imem_addr_o, 32'h0);
    exp_q.push_back(mk(32'h0));
    gnt_budget = 1;
    wait_drain(100, "restart");
    if (gnt_addrs.size() > 0) check("restart_addr", gnt_addrs[gnt_addrs.size() - 1], 32'h0);
    allow_stale = 1'b0;

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
